// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : light_pkg
//  Description : Shared types and constants for the light level driver and
//                the 4-level light FSM it commands.
//  Revision    : 1.0  initial release
// ============================================================================
package light_pkg;

    // Width of a light level (levels 0..3)
    localparam int LEVEL_W = 2;
    // Width of the shared step/gap timer
    localparam int TIMER_W = 4;

    typedef logic [LEVEL_W-1:0] level_t;

    // Level encodings shared with the light FSM
    localparam level_t L0 = 2'd0;
    localparam level_t L1 = 2'd1;
    localparam level_t L2 = 2'd2;
    localparam level_t L3 = 2'd3;

    // One-hot driver states
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_CHECK = 5'b00010,
        ST_PRESS = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_GAP   = 5'b10000
    } state_t;

endpackage : light_pkg
`default_nettype wire

// File: rtl/light_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : light_step_timer
//  Description : 4-bit counter with synchronous clear and count enable.
//                Flags terminal count when the value equals a runtime limit.
//                Used for both the step-confirm timeout and the idle gap.
//  Revision    : 1.0  initial release
// ============================================================================
module light_step_timer
    import light_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    input  logic [TIMER_W-1:0] limit,
    output logic               tc
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear has priority over enable
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule : light_step_timer
`default_nettype wire

// File: rtl/light_level_driver.sv
`default_nettype none
// ============================================================================
//  Module      : light_level_driver
//  Description : Command-side initiator for the 4-level light FSM. Accepts a
//                target level, pulses btn_up/btn_down one level at a time,
//                confirms each step on the light input, and reports done on
//                success or err when a step is not observed in time.
//  Revision    : 1.0  initial release
// ============================================================================
module light_level_driver
    import light_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4,  // WAIT cycles before err (1..15)
    parameter int unsigned GAP     = 1   // idle cycles after a step (0..15)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    input  logic [LEVEL_W-1:0] cmd_level,
    output logic               cmd_ready,
    input  logic [LEVEL_W-1:0] light,
    output logic               btn_up,
    output logic               btn_down,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Timer limits: terminal count is reached on the last cycle of a phase
    localparam logic [TIMER_W-1:0] c_wait_lim = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_gap_lim  = (GAP == 0) ? '0 : TIMER_W'(GAP - 1);

    state_t             state_q,    state_d;
    logic               btn_up_q,   btn_up_d;
    logic               btn_down_q, btn_down_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    level_t             target_q,   target_d;
    level_t             expected_q, expected_d;

    logic               tmr_clr;
    logic               tmr_en;
    logic [TIMER_W-1:0] tmr_limit;
    logic               tmr_tc;

    light_step_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .limit   (tmr_limit),
        .tc      (tmr_tc)
    );

    // Next-state and registered-output logic; pulses default low every cycle
    always_comb begin
        state_d    = state_q;
        btn_up_d   = 1'b0;
        btn_down_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        target_d   = target_q;
        expected_d = expected_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_limit  = c_gap_lim;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_level;
                    state_d  = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (light == target_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (light < target_q) begin
                    // light < 3 here, so the increment cannot wrap
                    btn_up_d   = 1'b1;
                    expected_d = light + 1'b1;
                    state_d    = ST_PRESS;
                end else begin
                    // light > 0 here, so the decrement cannot wrap
                    btn_down_d = 1'b1;
                    expected_d = light - 1'b1;
                    state_d    = ST_PRESS;
                end
            end

            ST_PRESS: begin
                // Button drops after exactly one cycle; start the timeout
                tmr_clr = 1'b1;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                tmr_limit = c_wait_lim;
                if (light == expected_q) begin
                    tmr_clr = 1'b1;
                    state_d = (GAP == 0) ? ST_CHECK : ST_GAP;
                end else if (tmr_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_GAP: begin
                if (tmr_tc) begin
                    state_d = ST_CHECK;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any command in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            btn_up_q   <= 1'b0;
            btn_down_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            target_q   <= L0;
            expected_q <= L0;
        end else begin
            state_q    <= state_d;
            btn_up_q   <= btn_up_d;
            btn_down_q <= btn_down_d;
            done_q     <= done_d;
            err_q      <= err_d;
            target_q   <= target_d;
            expected_q <= expected_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign btn_up    = btn_up_q;
    assign btn_down  = btn_down_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule : light_level_driver
`default_nettype wire

// File: tb/tb_light_level_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_level_driver
//  Description : Self-checking bench for light_level_driver with a small
//                behavioural light FSM attached. Expected button/done/err
//                events are queued with their cycle numbers when a command is
//                issued and matched as the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_light_level_driver;
    import light_pkg::*;

    typedef enum logic [1:0] {EV_UP, EV_DOWN, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    ev_t sb_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_level = 2'd0;
    logic         cmd_ready;
    logic [1:0]   light;
    logic         btn_up;
    logic         btn_down;
    logic         busy;
    logic         done;
    logic         err;

    // light FSM model controls
    logic         lm_load = 1'b0;
    logic [1:0]   lm_val  = 2'd0;
    logic         resp    = 1'b1;

    light_level_driver #(.TIMEOUT(4), .GAP(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_level (cmd_level),
        .cmd_ready (cmd_ready),
        .light     (light),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural 4-level light: one level per button cycle, saturating
    always @(posedge clk) begin
        if (lm_load) begin
            light <= lm_val;
        end else if (resp && btn_up && light != L3) begin
            light <= light + 2'd1;
        end else if (resp && btn_down && light != L0) begin
            light <= light - 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic exp_ev(input ev_kind_t k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic see(input ev_kind_t k);
        ev_t e;
        vectors++;
        assert (sb_q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_event observed kind=%0d at cycle %0d expected none", k, cyc);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    task automatic sample();
        ev_t e;
        while (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            vectors++;
            miscompares++;
            $error("FAIL missing_event observed none expected kind=%0d at cycle %0d", e.kind, e.cyc);
        end
        chk("buttons_exclusive", 32'(btn_up & btn_down), 0);
        chk("done_err_exclusive", 32'(done & err), 0);
        if (btn_up   !== 1'b0) see(EV_UP);
        if (btn_down !== 1'b0) see(EV_DOWN);
        if (done     !== 1'b0) see(EV_DONE);
        if (err      !== 1'b0) see(EV_ERR);
    endtask

    task automatic set_light(input logic [1:0] v, input logic r);
        lm_val  = v;
        lm_load = 1'b1;
        resp    = r;
        @(negedge clk);
        lm_load = 1'b0;
    endtask

    // Issue a command at cycle 0 (accept edge ends cycle 0) and run ncyc
    // cycles. cmd_level switches to busy_lvl from cycle 1, cmd_valid drops at
    // cycle hold_until, and reset is pulsed from cycle rst_at (0 = never).
    task automatic run_cmd(input logic [1:0] lvl, input logic [1:0] busy_lvl,
                           input int hold_until, input int ncyc, input int rst_at,
                           input logic [1:0] exp_light);
        cmd_level = lvl;
        cmd_valid = 1'b1;
        cyc       = 0;
        chk("ready_before_accept", 32'(cmd_ready), 1);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            cyc = i;
            sample();
            if (i == 1) begin
                chk("busy_in_check", 32'(busy), 1);
                chk("ready_in_check", 32'(cmd_ready), 0);
                cmd_level = busy_lvl;
            end
            if (i >= hold_until) cmd_valid = 1'b0;
            if (i == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("btn_up_async_reset", 32'(btn_up), 0);
                chk("btn_down_async_reset", 32'(btn_down), 0);
                chk("ready_async_reset", 32'(cmd_ready), 1);
            end
            if (rst_at != 0 && i == rst_at + 2) reset_n = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("ready_after_cmd", 32'(cmd_ready), 1);
        chk("light_after_cmd", 32'(light), 32'(exp_light));
        vectors++;
        assert (sb_q.size() == 0) else begin
            miscompares++;
            $error("FAIL leftover_events observed=%0d expected=0", sb_q.size());
        end
        sb_q.delete();
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        set_light(L0, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_btn_up", 32'(btn_up), 0);
        chk("rst_btn_down", 32'(btn_down), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 0 -> 3: three up steps, done at 4N+2
        exp_ev(EV_UP, 2); exp_ev(EV_UP, 6); exp_ev(EV_UP, 10); exp_ev(EV_DONE, 14);
        run_cmd(L3, L3, 1, 16, 0, L3);

        // 3 -> 1: two down steps
        exp_ev(EV_DOWN, 2); exp_ev(EV_DOWN, 6); exp_ev(EV_DONE, 10);
        run_cmd(L1, L1, 1, 12, 0, L1);

        // 1 -> 2, then 2 -> 2 with no button activity
        exp_ev(EV_UP, 2); exp_ev(EV_DONE, 6);
        run_cmd(L2, L2, 1, 8, 0, L2);
        exp_ev(EV_DONE, 2);
        run_cmd(L2, L2, 1, 4, 0, L2);

        // Unresponsive light: single up pulse, err five cycles after PRESS
        set_light(L0, 1'b0);
        exp_ev(EV_UP, 2); exp_ev(EV_ERR, 7);
        run_cmd(L1, L1, 1, 10, 0, L0);

        // cmd_valid held through a busy command with level changed to 0;
        // back-to-back accept in the done cycle
        set_light(L0, 1'b1);
        exp_ev(EV_UP, 2); exp_ev(EV_UP, 6); exp_ev(EV_DONE, 10);
        exp_ev(EV_DOWN, 12); exp_ev(EV_DOWN, 16); exp_ev(EV_DONE, 20);
        run_cmd(L2, L0, 11, 22, 0, L0);

        // Reset during PRESS: light never moves
        set_light(L0, 1'b1);
        exp_ev(EV_UP, 2);
        run_cmd(L2, L2, 1, 8, 2, L0);

        // Reset during WAIT: the one pressed step has already landed
        exp_ev(EV_UP, 2);
        run_cmd(L2, L2, 1, 8, 3, L1);

        // Normal 0 -> 2 after the aborted commands
        set_light(L0, 1'b1);
        exp_ev(EV_UP, 2); exp_ev(EV_UP, 6); exp_ev(EV_DONE, 10);
        run_cmd(L2, L2, 1, 12, 0, L2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_light_level_driver
`default_nettype wire
